csr_unit: RTL

- Machine-mode CSR file and trap controller for the 5-stage RV32I pipeline.
- It is the responder for the CSR address, CSR data and trap code/flag that the decode stage produces.
- Services CSR read/modify/write instructions (issued from EX), records traps and external interrupts, and returns the redirect target (mtvec / mepc) to the fetch stage.
- Owns the mcycle/minstret counters.

---
 rtl/csr_unit_if.sv | 34 +++
 rtl/csr_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - CSR access, trap and redirect signals between the pipeline and csr_unit.
interface csr_unit_if;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        is_rs0_i;
  logic [31:0] csr_rdata_o;
  logic        illegal_csr_o;
  logic        trap_i;
  logic [3:0]  trap_code_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_val_i;
  logic        mret_i;
  logic        irq_ext_i;
  logic        irq_ok_i;
  logic [31:0] irq_pc_i;
  logic        retire_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output csr_op_i, csr_addr_i, csr_wdata_i, is_rs0_i,
    output trap_i, trap_code_i, trap_pc_i, trap_val_i, mret_i,
    output irq_ext_i, irq_ok_i, irq_pc_i, retire_i,
    input  csr_rdata_o, illegal_csr_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  csr_op_i, csr_addr_i, csr_wdata_i, is_rs0_i,
    input  trap_i, trap_code_i, trap_pc_i, trap_val_i, mret_i,
    input  irq_ext_i, irq_ok_i, irq_pc_i, retire_i,
    output csr_rdata_o, illegal_csr_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file, trap/interrupt entry, MRET and 64-bit counters.
// Reads and illegal detection are combinational; all state updates land on the next clk edge.
module csr_unit #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h40000100,
  parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
  input  logic     clk,
  input  logic     rst_n,
  csr_unit_if.slave bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] IRQ_CAUSE   = 32'h8000000B;
  localparam logic [31:0] ALIGN4_MASK = 32'hFFFFFFFC;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  logic        mie_q;
  logic        mpie_q;
  logic        meie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
  logic [63:0] mcycle_d;
  logic [63:0] minstret_d;

  csr_op_e     op;
  logic [11:0] addr;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        addr_known;
  logic        op_active;
  logic        wr_eff;
  logic        illegal;
  logic        irq_take;
  logic        exc_take;
  logic        csr_we;

  assign op        = csr_op_e'(bus.csr_op_i);
  assign addr      = bus.csr_addr_i;
  assign op_active = (op != OP_NONE);
  // RS/RC with a zero source register only reads, so it may target read-only CSRs
  assign wr_eff    = (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && !bus.is_rs0_i);

  always_comb begin
    old_val    = 32'h0;
    addr_known = 1'b1;
    case (addr)
      A_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      A_MISA:      old_val = MISA_VAL;
      A_MIE:       old_val = {20'b0, meie_q, 11'b0};
      A_MTVEC:     old_val = mtvec_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MTVAL:     old_val = mtval_q;
      A_MIP:       old_val = {20'b0, bus.irq_ext_i, 11'b0};
      A_MCYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH:   old_val = mcycle_q[63:32];
      A_MINSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH: old_val = minstret_q[63:32];
      A_MHARTID:   old_val = HART_ID;
      default:     addr_known = 1'b0;
    endcase
  end

  always_comb begin
    new_val = bus.csr_wdata_i;
    case (op)
      OP_RS:   new_val = old_val | bus.csr_wdata_i;
      OP_RC:   new_val = old_val & ~bus.csr_wdata_i;
      default: new_val = bus.csr_wdata_i;
    endcase
  end

  assign illegal  = op_active && (!addr_known || (wr_eff && (addr[11:10] == 2'b11)));
  assign irq_take = bus.irq_ext_i && mie_q && meie_q && bus.irq_ok_i && !bus.trap_i;
  assign exc_take = bus.trap_i || irq_take;
  // Trap, interrupt and MRET all outrank an instruction's CSR write in the same cycle
  assign csr_we   = wr_eff && !illegal && !exc_take && !bus.mret_i;

  assign bus.csr_rdata_o   = op_active ? old_val : 32'h0;
  assign bus.illegal_csr_o = illegal;
  assign bus.redirect_o    = exc_take || bus.mret_i;
  assign bus.redirect_pc_o = exc_take   ? mtvec_q :
                             bus.mret_i ? mepc_q  : 32'h0;

  // A write to either half replaces the whole counter's increment for that cycle
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, bus.retire_i};
    if (csr_we) begin
      case (addr)
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
        A_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
        A_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & ALIGN4_MASK;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (exc_take) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
        if (bus.trap_i) begin
          mepc_q   <= bus.trap_pc_i & ALIGN4_MASK;
          mcause_q <= {28'b0, bus.trap_code_i};
          mtval_q  <= bus.trap_val_i;
        end else begin
          mepc_q   <= bus.irq_pc_i & ALIGN4_MASK;
          mcause_q <= IRQ_CAUSE;
          mtval_q  <= 32'h0;
        end
      end else if (bus.mret_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (addr)
          A_MSTATUS: begin
            mie_q  <= new_val[3];
            mpie_q <= new_val[7];
          end
          A_MIE:      meie_q     <= new_val[11];
          A_MTVEC:    mtvec_q    <= new_val & ALIGN4_MASK;
          A_MSCRATCH: mscratch_q <= new_val;
          A_MEPC:     mepc_q     <= new_val & ALIGN4_MASK;
          A_MCAUSE:   mcause_q   <= new_val;
          A_MTVAL:    mtval_q    <= new_val;
          default: ;
        endcase
      end
    end
  end

endmodule
